// File: rtl/mult_acc_pkg.sv
// Shared types and constants for the multiply-accumulate datapath.
package mult_acc_pkg;

    localparam int PROD_W_DEF = 16;
    localparam int ACC_W_DEF  = 24;
    localparam int LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Largest positive two's-complement value of a w-bit word (low w bits valid).
    function automatic logic [63:0] acc_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Most negative two's-complement value of a w-bit word (low w bits valid).
    function automatic logic [63:0] acc_min(input int w);
        return ~acc_max(w);
    endfunction

endpackage

// File: rtl/mult_accumulator_add_sat.sv
// Combinational accumulator adder: sign-extends the product, flags signed overflow,
// and clamps to the signed range when MULT_ACC_SAT_EN is defined (wraps otherwise).
module acc_add_sat
    import mult_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF
) (
    input  logic [ACC_W-1:0]  acc_in,
    input  logic [PROD_W-1:0] prod,
    output logic [ACC_W-1:0]  sum,
    output logic              ovf
);

    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] raw_sum;

    generate
        if (ACC_W > PROD_W) begin : g_ext
            assign prod_ext = {{(ACC_W - PROD_W){prod[PROD_W-1]}}, prod};
        end else begin : g_noext
            assign prod_ext = prod;
        end
    endgenerate

    assign raw_sum = acc_in + prod_ext;
    assign ovf     = (acc_in[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (raw_sum[ACC_W-1] != acc_in[ACC_W-1]);

`ifdef MULT_ACC_SAT_EN
    localparam logic [63:0]      MAX64   = acc_max(ACC_W);
    localparam logic [63:0]      MIN64   = acc_min(ACC_W);
    localparam logic [ACC_W-1:0] SAT_MAX = MAX64[ACC_W-1:0];
    localparam logic [ACC_W-1:0] SAT_MIN = MIN64[ACC_W-1:0];

    // Overflow can only happen toward the common operand sign.
    assign sum = ovf ? (acc_in[ACC_W-1] ? SAT_MIN : SAT_MAX) : raw_sum;
`else
    assign sum = raw_sum;
`endif

endmodule

// File: rtl/mult_accumulator.sv
// Sequential MAC behind the 8x8 signed multiplier: sums len products into acc.
// Saturating arithmetic is selected with the MULT_ACC_SAT_EN macro (default: wrap).
module mult_accumulator
    import mult_acc_pkg::*;
#(
    parameter int PROD_W = PROD_W_DEF,
    parameter int ACC_W  = ACC_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  acc,
    output logic              acc_valid,
    input  logic              acc_ready,
    output logic              busy,
    output logic              ovf
);

    state_t             state_reg;
    logic [ACC_W-1:0]   acc_reg;
    logic [ACC_W-1:0]   sum_next;
    logic [LEN_W-1:0]   count_reg;
    logic               ovf_reg;
    logic               prod_ready_reg;
    logic               acc_valid_reg;
    logic               busy_reg;
    logic               add_ovf;
    logic               xfer;

    acc_add_sat #(
        .PROD_W (PROD_W),
        .ACC_W  (ACC_W)
    ) u_add (
        .acc_in (acc_reg),
        .prod   (prod),
        .sum    (sum_next),
        .ovf    (add_ovf)
    );

    assign xfer = prod_valid && prod_ready_reg;

    // Handshake outputs are registered alongside the state so they track it exactly.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            acc_reg        <= '0;
            count_reg      <= '0;
            ovf_reg        <= 1'b0;
            prod_ready_reg <= 1'b0;
            acc_valid_reg  <= 1'b0;
            busy_reg       <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        acc_reg   <= '0;
                        ovf_reg   <= 1'b0;
                        count_reg <= len;
                        busy_reg  <= 1'b1;
                        if (len == '0) begin
                            state_reg     <= DONE;
                            acc_valid_reg <= 1'b1;
                        end else begin
                            state_reg      <= ACCUM;
                            prod_ready_reg <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (xfer) begin
                        acc_reg   <= sum_next;
                        count_reg <= count_reg - LEN_W'(1);
                        if (add_ovf) begin
                            ovf_reg <= 1'b1;
                        end
                        if (count_reg == LEN_W'(1)) begin
                            state_reg      <= DONE;
                            prod_ready_reg <= 1'b0;
                            acc_valid_reg  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (acc_ready) begin
                        state_reg     <= IDLE;
                        acc_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                    end
                end
                default: begin
                    state_reg      <= IDLE;
                    prod_ready_reg <= 1'b0;
                    acc_valid_reg  <= 1'b0;
                    busy_reg       <= 1'b0;
                end
            endcase
        end
    end

    assign prod_ready = prod_ready_reg;
    assign acc_valid  = acc_valid_reg;
    assign busy       = busy_reg;
    assign acc        = acc_reg;
    assign ovf        = ovf_reg;

endmodule

// File: tb/tb_mult_accumulator.sv
// Scoreboard bench: a 24-bit and a 16-bit accumulator share one stimulus stream;
// expected results come from an integer reference model of wrap/saturate arithmetic.
module tb_mult_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [15:0] prod;
    logic        prod_valid;
    logic        acc_ready;

    logic        prod_ready24, acc_valid24, busy24, ovf24;
    logic [23:0] acc24;
    logic        prod_ready16, acc_valid16, busy16, ovf16;
    logic [15:0] acc16;

    typedef struct {
        longint a24;
        bit     o24;
        longint a16;
        bit     o16;
    } exp_t;

    exp_t               exp_q[$];
    logic signed [15:0] prod_list[$];
    int                 errors = 0;
    int                 checks = 0;

    always #5 clk = ~clk;

    mult_accumulator #(.PROD_W(16), .ACC_W(24), .LEN_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(prod_ready24), .acc(acc24),
        .acc_valid(acc_valid24), .acc_ready(acc_ready), .busy(busy24), .ovf(ovf24)
    );

    mult_accumulator #(.PROD_W(16), .ACC_W(16), .LEN_W(8)) dut16 (
        .clk(clk), .rst(rst), .start(start), .len(len), .prod(prod),
        .prod_valid(prod_valid), .prod_ready(prod_ready16), .acc(acc16),
        .acc_valid(acc_valid16), .acc_ready(acc_ready), .busy(busy16), .ovf(ovf16)
    );

    // Reference: exact integer sum, then wrap or clamp into a w-bit signed range.
    function automatic longint model_add(input longint a, input longint p, input int w,
                                         inout bit o);
        longint mx = (longint'(1) << (w - 1)) - 1;
        longint mn = -mx - 1;
        longint s  = a + p;
        if (s > mx || s < mn) begin
            o = 1'b1;
`ifdef MULT_ACC_SAT_EN
            s = (s > mx) ? mx : mn;
`else
            s = (s > mx) ? s - (longint'(1) << w) : s + (longint'(1) << w);
`endif
        end
        return s;
    endfunction

    task automatic drive_run(input int n, input bit bubbles, input string name);
        exp_t e;
        int   idx = 0;
        int   cyc = 0;
        int   want_cyc;
        e.a24 = 0; e.o24 = 1'b0; e.a16 = 0; e.o16 = 1'b0;
        for (int i = 0; i < n; i++) begin
            e.a24 = model_add(e.a24, longint'(prod_list[i]), 24, e.o24);
            e.a16 = model_add(e.a16, longint'(prod_list[i]), 16, e.o16);
        end
        exp_q.push_back(e);
        start = 1'b1;
        len   = n[7:0];
        @(negedge clk);
        start = 1'b0;
        while (idx < n && cyc < 100) begin
            if (bubbles && (cyc % 2 == 1)) begin
                prod_valid = 1'b0;
            end else begin
                prod_valid = 1'b1;
                prod       = prod_list[idx];
            end
            if (prod_valid && prod_ready24) idx++;
            @(negedge clk);
            cyc++;
        end
        prod_valid = 1'b0;
        checks++;
        if (idx != n) begin
            errors++;
            $display("FAIL %s transfers: got %0d expected %0d", name, idx, n);
        end
        want_cyc = (n == 0) ? 0 : (bubbles ? 2 * n - 1 : n);
        checks++;
        if (acc_valid24 !== 1'b1 || cyc != want_cyc) begin
            errors++;
            $display("FAIL %s latency: acc_valid=%b after %0d cycles, expected 1 after %0d",
                     name, acc_valid24, cyc, want_cyc);
        end
    endtask

    task automatic collect(input string name, input bit start_at_handshake);
        exp_t   e;
        longint got;
        int     w = 0;
        while (acc_valid24 !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (acc_valid24 !== 1'b1 || acc_valid16 !== 1'b1) begin
            errors++;
            $display("FAIL %s acc_valid timeout: got %b/%b expected 1/1",
                     name, acc_valid24, acc_valid16);
        end
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue expected an entry", name);
            return;
        end
        e = exp_q.pop_front();
        got = longint'($signed(acc24));
        checks++;
        if (got !== e.a24 || ovf24 !== e.o24) begin
            errors++;
            $display("FAIL %s acc24: got %0d ovf=%b expected %0d ovf=%b",
                     name, got, ovf24, e.a24, e.o24);
        end
        got = longint'($signed(acc16));
        checks++;
        if (got !== e.a16 || ovf16 !== e.o16) begin
            errors++;
            $display("FAIL %s acc16: got %0d ovf=%b expected %0d ovf=%b",
                     name, got, ovf16, e.a16, e.o16);
        end
        acc_ready = 1'b1;
        start     = start_at_handshake;
        len       = 8'd3;
        @(negedge clk);
        acc_ready = 1'b0;
        start     = 1'b0;
        checks++;
        if (busy24 !== 1'b0 || acc_valid24 !== 1'b0 || prod_ready24 !== 1'b0) begin
            errors++;
            $display("FAIL %s after take: got busy=%b acc_valid=%b prod_ready=%b expected 0/0/0",
                     name, busy24, acc_valid24, prod_ready24);
        end
        got = longint'($signed(acc16));
        checks++;
        if (got !== e.a16 || ovf16 !== e.o16) begin
            errors++;
            $display("FAIL %s idle hold: got %0d ovf=%b expected %0d ovf=%b",
                     name, got, ovf16, e.a16, e.o16);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; len = '0; prod = '0; prod_valid = 1'b0; acc_ready = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({prod_ready24, acc_valid24, busy24, ovf24, acc24} !== '0 ||
            {prod_ready16, acc_valid16, busy16, ovf16, acc16} !== '0) begin
            errors++;
            $display("FAIL reset: got acc24=%h acc16=%h flags=%b%b%b%b expected all 0",
                     acc24, acc16, prod_ready24, acc_valid24, busy24, ovf24);
        end
        rst = 1'b0;
        @(negedge clk);
        $display("test_reset done");
    endtask

    task automatic test_basic();
        prod_list = '{16'sd100, -16'sd50, 16'sd7};
        drive_run(3, 1'b0, "basic");
        collect("basic", 1'b0);
        $display("test_basic done");
    endtask

    task automatic test_zero_len();
        prod_list = {};
        drive_run(0, 1'b0, "zero_len");
        checks++;
        if (prod_ready24 !== 1'b0 || busy24 !== 1'b1) begin
            errors++;
            $display("FAIL zero_len ready: got prod_ready=%b busy=%b expected 0/1",
                     prod_ready24, busy24);
        end
        collect("zero_len", 1'b0);
        $display("test_zero_len done");
    endtask

    task automatic test_bubbles_backpressure();
        logic [23:0] held;
        prod_list = '{-16'sd16384, -16'sd16384, -16'sd16384, -16'sd16384};
        drive_run(4, 1'b1, "bubbles");
        held = acc24;
        for (int i = 0; i < 5; i++) begin
            start = 1'b1;
            len   = 8'd2;
            @(negedge clk);
            checks++;
            if (acc_valid24 !== 1'b1 || acc24 !== held || busy24 !== 1'b1) begin
                errors++;
                $display("FAIL backpressure hold %0d: got acc=%h valid=%b busy=%b expected %h/1/1",
                         i, acc24, acc_valid24, busy24, held);
            end
        end
        start = 1'b0;
        collect("bubbles", 1'b1);
        $display("test_bubbles_backpressure done");
    endtask

    task automatic test_overflow();
        prod_list = '{16'sh7FFF, 16'sh0001};
        drive_run(2, 1'b0, "ovf_pos");
        collect("ovf_pos", 1'b0);
        prod_list = '{16'sh8000, 16'shFFFF};
        drive_run(2, 1'b0, "ovf_neg");
        collect("ovf_neg", 1'b0);
        $display("test_overflow done");
    endtask

    task automatic test_reset_mid_run();
        start = 1'b1;
        len   = 8'd4;
        @(negedge clk);
        start      = 1'b0;
        prod_valid = 1'b1;
        prod       = 16'sd3;
        repeat (2) @(negedge clk);
        prod_valid = 1'b0;
        rst        = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({prod_ready24, acc_valid24, busy24, ovf24, acc24} !== '0) begin
            errors++;
            $display("FAIL mid_reset: got acc=%h prod_ready=%b acc_valid=%b busy=%b expected all 0",
                     acc24, prod_ready24, acc_valid24, busy24);
        end
        @(negedge clk);
        prod_list = '{16'sd5};
        drive_run(1, 1'b0, "after_reset");
        collect("after_reset", 1'b0);
        $display("test_reset_mid_run done");
    endtask

    task automatic test_sticky_clear();
        prod_list = '{16'sh7FFF, 16'sh0001};
        drive_run(2, 1'b0, "sticky_ovf");
        collect("sticky_ovf", 1'b0);
        prod_list = '{16'sd1};
        drive_run(1, 1'b0, "sticky_clear");
        collect("sticky_clear", 1'b0);
        $display("test_sticky_clear done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_bubbles_backpressure();
        test_overflow();
        test_reset_mid_run();
        test_sticky_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
